// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply/divide unit with HI/LO registers (radix-2, 33-cycle latency).
// Define MDU_SIGNED_EN to enable signed MULT/DIV; otherwise op[0] is ignored and everything is unsigned.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        hiWre,
    input  logic        loWre,
    input  logic [31:0] hiLoIn,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  dbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } stateT;

    stateT       state;
    stateT       nextState;
    logic [5:0]  count;
    logic [31:0] accHi;
    logic [31:0] accLo;
    logic [31:0] opB;
    logic        isDiv;
    logic        negRes;
    logic        negRem;

    logic        accept;
    logic        opSigned;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [32:0] mulSum;
    logic [32:0] divShift;
    logic        divFits;
    logic [31:0] divRem;
    logic [63:0] prodFix;
    logic [31:0] quoFix;
    logic [31:0] remFix;

`ifdef MDU_SIGNED_EN
    assign opSigned = op[0];
`else
    logic unusedOp;
    assign unusedOp = op[0];
    assign opSigned = 1'b0;
`endif

    assign accept   = (state == IDLE) && start;
    assign busy     = (state != IDLE);
    assign dbgState = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = CALC;
            CALC:    if (count == 6'd31) nextState = FIX;
            FIX:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Iterations run on magnitudes; signs are folded back in during FIX.
    assign magA = (opSigned && srcA[31]) ? (32'd0 - srcA) : srcA;
    assign magB = (opSigned && srcB[31]) ? (32'd0 - srcB) : srcB;

    // Multiply: accHi accumulates, accLo shifts out multiplier bits and collects product low bits.
    assign mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : 33'd0);

    // Restoring divide: accHi is the partial remainder, accLo shifts dividend out and quotient in.
    assign divShift = {accHi, accLo[31]};
    assign divFits  = (divShift >= {1'b0, opB});
    assign divRem   = divShift[31:0] - opB;

    assign prodFix = negRes ? (64'd0 - {accHi, accLo}) : {accHi, accLo};
    assign quoFix  = negRes ? (32'd0 - accLo) : accLo;
    assign remFix  = negRem ? (32'd0 - accHi) : accHi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= 6'd0;
            accHi  <= 32'd0;
            accLo  <= 32'd0;
            opB    <= 32'd0;
            isDiv  <= 1'b0;
            negRes <= 1'b0;
            negRem <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            done   <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (accept) begin
                        count  <= 6'd0;
                        accHi  <= 32'd0;
                        accLo  <= magA;
                        opB    <= magB;
                        isDiv  <= op[1];
                        // Divide-by-zero keeps the all-ones quotient unnegated.
                        negRes <= opSigned && (srcA[31] ^ srcB[31]) && !(op[1] && (srcB == 32'd0));
                        negRem <= opSigned && srcA[31];
                    end else begin
                        if (hiWre) hi <= hiLoIn;
                        if (loWre) lo <= hiLoIn;
                    end
                end
                CALC: begin
                    count <= (count == 6'd31) ? 6'd0 : count + 6'd1;
                    if (isDiv) begin
                        accHi <= divFits ? divRem : divShift[31:0];
                        accLo <= {accLo[30:0], divFits};
                    end else begin
                        {accHi, accLo} <= {mulSum, accLo[31:1]};
                    end
                end
                FIX: begin
                    if (isDiv) begin
                        hi <= remFix;
                        lo <= quoFix;
                    end else begin
                        hi <= prodFix[63:32];
                        lo <= prodFix[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL: clk  input  1  clock, all state updates on rising edge.
REQ-002 SHALL: reset  input  1  reset, asynchronous and active-high.
REQ-003 SHALL: start  input  1  request new operation; sampled only in IDLE.
REQ-004 SHALL: op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-005 SHALL: srcA  input  32  operand A from register-file read port 1 (multiplicand / dividend).
REQ-006 SHALL: srcB  input  32  operand B from register-file read port 2 (multiplier / divisor).
REQ-007 SHALL: hiWre  input  1  MTHI write enable.
REQ-008 SHALL: loWre  input  1  MTLO write enable.
REQ-009 SHALL: hiLoIn  input  32  data for MTHI/MTLO.
REQ-010 SHALL: busy  output  1  high while an operation is in progress (CALC, FIX).
REQ-011 SHALL: done  output  1  one-cycle completion pulse, registered.
REQ-012 SHALL: hi  output  32  HI register (product high word / remainder).
REQ-013 SHALL: lo  output  32  LO register (product low word / quotient).

Function
REQ-014 SHALL: FSM states IDLE, CALC, FIX; IDLE->CALC on start, CALC->FIX after 32 iterations, FIX->IDLE unconditionally.
REQ-015 SHALL: on accepting start, latch op, srcA, srcB; operand changes while busy have no effect.
REQ-016 SHALL: CALC perform one radix-2 step per cycle (shift-add multiply, restoring divide) on operand magnitudes, 6-bit iteration counter 0..31.
REQ-017 SHALL: FIX apply sign correction, write hi/lo, set done; done high exactly the one cycle after FIX, i.e. 33 cycles after the start-accept edge.
REQ-018 SHALL: busy=1 in CALC and FIX, busy=0 in IDLE, including the cycle done is high.
REQ-019 SHALL: multiply: {hi,lo} = full 64-bit product.
REQ-020 SHALL: divide: lo = quotient truncated toward zero, hi = remainder with sign of dividend.
REQ-021 SHALL: divide by zero: lo=0xFFFFFFFF, hi=dividend (unsigned value, or sign-preserving for DIV), normal latency.
REQ-022 SHALL: DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
REQ-023 SHALL: start asserted while busy ignored; no queuing.
REQ-024 SHALL: hiWre/loWre in IDLE without start write hiLoIn into hi/lo at next edge; both may fire together.
REQ-025 SHALL: hiWre/loWre ignored while busy, and ignored in the IDLE cycle that start is accepted (start has priority).
REQ-026 SHALL: hi/lo hold value at all other times; unaffected during CALC.

Reset
REQ-027 SHALL: reset forces state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0 immediately.
REQ-028 SHALL: reset during CALC/FIX abort the operation, no done pulse, hi/lo=0.
REQ-029 SHALL: first start accepted on the first rising edge after reset deassertion.

Configuration
REQ-030 SHALL: macro MDU_SIGNED_EN defined: MULT and DIV take two's-complement operands with sign correction in FIX.
REQ-031 SHALL: MDU_SIGNED_EN undefined: op[0] ignored, all operations unsigned, FIX only writes results; latency unchanged.

Verification
REQ-032 SHALL: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done 33 cycles after start.
REQ-033 SHALL: MULT -3 x 5 (signed build) -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-034 SHALL: DIV -7 / 2 (signed build) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064.
REQ-035 SHALL: start MULTU 6x7, reset pulsed in 10th CALC cycle -> hi=lo=0, busy=0, no done; rerun gives lo=0x0000002A.
REQ-036 SHALL: start re-asserted and hiWre=1 with hiLoIn=0x12345678 during busy -> ignored, result of first op only, one done pulse.
REQ-037 SHALL: IDLE hiWre=1 loWre=1 hiLoIn=0xCAFEF00D -> hi=lo=0xCAFEF00D next edge; same with start=1 -> write dropped, operation runs.
